// File: rtl/ct_spsram_2048x32_arb.sv
// Round-robin arbiter for two requesters sharing one single-port SRAM (2048x32 by default).
// Optional macro CT_SPSRAM_ARB_INIT_EN: after reset, zero every word before accepting requests.
`timescale 1ns/1ps
module ct_spsram_2048x32_arb #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst,
    input  logic                      a_req,
    input  logic                      b_req,
    input  logic                      a_we,
    input  logic                      b_we,
    input  logic [ADDR_WIDTH-1:0]     a_addr,
    input  logic [ADDR_WIDTH-1:0]     b_addr,
    input  logic [DATA_WIDTH-1:0]     a_wdata,
    input  logic [DATA_WIDTH-1:0]     b_wdata,
    input  logic [DATA_WIDTH/8-1:0]   a_be,
    input  logic [DATA_WIDTH/8-1:0]   b_be,
    output logic                      a_gnt,
    output logic                      b_gnt,
    output logic                      a_rvld,
    output logic                      b_rvld,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      arb_ready,
    output logic                      sram_cen,
    output logic                      sram_gwen,
    output logic [DATA_WIDTH-1:0]     sram_wen,
    output logic [ADDR_WIDTH-1:0]     sram_a,
    output logic [DATA_WIDTH-1:0]     sram_d,
    input  logic [DATA_WIDTH-1:0]     sram_q
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                  w_run;
    logic                  w_init_wr;
    logic [ADDR_WIDTH-1:0] w_init_addr;
    logic                  w_a_gnt;
    logic                  w_b_gnt;
    logic                  w_we;
    logic [BE_W-1:0]       w_be;
    logic [DATA_WIDTH-1:0] w_wen;
    logic                  r_ptr;
    logic                  r_a_rvld;
    logic                  r_b_rvld;

`ifdef CT_SPSRAM_ARB_INIT_EN
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;

    // Counter parks at the last address so the final zero write is issued once.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else if (r_state == ST_INIT) begin
            if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
                r_state <= ST_RUN;
            end else begin
                r_cnt <= r_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign w_run       = (r_state == ST_RUN) & ~cpurst;
    assign w_init_wr   = (r_state == ST_INIT) & ~cpurst;
    assign w_init_addr = r_cnt;
    assign arb_ready   = (r_state == ST_RUN);
`else
    assign w_run       = ~cpurst;
    assign w_init_wr   = 1'b0;
    assign w_init_addr = '0;
    assign arb_ready   = 1'b1;
`endif

    // r_ptr = 0 favours A, 1 favours B; only consulted when both request.
    assign w_a_gnt = w_run & a_req & (~b_req | ~r_ptr);
    assign w_b_gnt = w_run & b_req & (~a_req |  r_ptr);
    assign a_gnt   = w_a_gnt;
    assign b_gnt   = w_b_gnt;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_ptr    <= 1'b0;
            r_a_rvld <= 1'b0;
            r_b_rvld <= 1'b0;
        end else begin
            if (w_run & a_req & b_req) begin
                r_ptr <= ~r_ptr;
            end
            r_a_rvld <= w_a_gnt & ~a_we;
            r_b_rvld <= w_b_gnt & ~b_we;
        end
    end

    assign a_rvld = r_a_rvld;
    assign b_rvld = r_b_rvld;
    assign rdata  = (r_a_rvld | r_b_rvld) ? sram_q : '0;

    assign w_we = w_b_gnt ? b_we : a_we;
    assign w_be = w_b_gnt ? b_be : a_be;

    always_comb begin
        w_wen = '1;
        for (int i = 0; i < BE_W; i++) begin
            w_wen[i*8 +: 8] = {8{~(w_we & w_be[i])}};
        end
    end

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = w_b_gnt ? b_addr : a_addr;
        sram_d    = w_b_gnt ? b_wdata : a_wdata;
        if (w_init_wr) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = w_init_addr;
            sram_d    = '0;
        end else if (w_a_gnt | w_b_gnt) begin
            sram_cen  = 1'b0;
            sram_gwen = ~w_we;
            sram_wen  = w_wen;
        end
    end
endmodule

// File: tb/tb_ct_spsram_2048x32_arb.sv
// Scoreboard bench for ct_spsram_2048x32_arb: behavioural SRAM, reference memory image and
// round-robin prediction; a separate monitor checks every read return.
`timescale 1ns/1ps
module tb_ct_spsram_2048x32_arb;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 2048;
`ifdef CT_SPSRAM_ARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    typedef struct {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
    } rq_t;

    typedef struct {
        int            who;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, b_req, a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic [3:0]    a_be, b_be;
    logic          a_gnt, b_gnt, a_rvld, b_rvld, arb_ready;
    logic [DW-1:0] rdata;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, sram_q;
    logic [AW-1:0] sram_a;

    always #5 clk = ~clk;

    ct_spsram_2048x32_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk(clk), .cpurst(rst),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_be(a_be), .b_be(b_be), .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_rvld(a_rvld), .b_rvld(b_rvld), .rdata(rdata), .arb_ready(arb_ready),
        .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    // Behavioural single-port SRAM: bit-masked write, registered read.
    logic [DW-1:0] sram_arr [DEPTH];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                sram_arr[sram_a] <= (sram_arr[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end else begin
                sram_q <= sram_arr[sram_a];
            end
        end
    end

    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          sb_q [$];
    int            ptr_m = 0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mon_en = 1'b0;
    logic          last_a_gnt, last_b_gnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            chk("rvld_onehot", a_rvld & b_rvld, 0);
            if (a_rvld || b_rvld) begin
                if (sb_q.size() == 0) begin
                    chk("rvld_unexpected", {a_rvld, b_rvld}, 2'b00);
                end else begin
                    e = sb_q.pop_front();
                    chk("rvld_who", {a_rvld, b_rvld}, (e.who == 0) ? 2'b10 : 2'b01);
                    chk("rdata", rdata, e.data);
                    chk("rvld_latency", cyc, e.due);
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                chk("rvld_missing", {a_rvld, b_rvld}, (e.who == 0) ? 2'b10 : 2'b01);
            end
        end
    end

    // Called at posedge+1; drives one cycle, predicts grant and SRAM controls, returns at posedge+1.
    task automatic step(input rq_t ra, input rq_t rb, output logic ga, output logic gb);
        logic          ega, egb;
        rq_t           w;
        logic [DW-1:0] exp_wen;
        a_req = ra.req; a_we = ra.we; a_addr = ra.addr; a_wdata = ra.wdata; a_be = ra.be;
        b_req = rb.req; b_we = rb.we; b_addr = rb.addr; b_wdata = rb.wdata; b_be = rb.be;
        @(negedge clk);
        ega = ra.req && (!rb.req || ptr_m == 0);
        egb = rb.req && (!ra.req || ptr_m == 1);
        if (ra.req && rb.req) ptr_m = 1 - ptr_m;
        last_a_gnt = a_gnt;
        last_b_gnt = b_gnt;
        chk("a_gnt", a_gnt, ega);
        chk("b_gnt", b_gnt, egb);
        chk("arb_ready", arb_ready, 1);
        if (ega || egb) begin
            w = ega ? ra : rb;
            for (int b = 0; b < 4; b++) exp_wen[8*b +: 8] = (w.we && w.be[b]) ? 8'h00 : 8'hFF;
            chk("sram_cen", sram_cen, 0);
            chk("sram_a", sram_a, w.addr);
            chk("sram_gwen", sram_gwen, !w.we);
            chk("sram_wen", sram_wen, exp_wen);
            if (w.we) begin
                chk("sram_d", sram_d, w.wdata);
                for (int b = 0; b < 4; b++)
                    if (w.be[b]) ref_mem[w.addr][8*b +: 8] = w.wdata[8*b +: 8];
            end else begin
                sb_q.push_back('{who: (ega ? 0 : 1), data: ref_mem[w.addr], due: cyc + 1});
            end
        end else begin
            chk("idle_cen", sram_cen, 1);
            chk("idle_gwen", sram_gwen, 1);
            chk("idle_wen", sram_wen, {DW{1'b1}});
        end
        ga = ega;
        gb = egb;
        @(posedge clk);
        #1;
    endtask

    task automatic init_sweep(input int n);
        for (int k = 0; k < n; k++) begin
            a_req = 1'b1; b_req = 1'b1;
            @(negedge clk);
            chk("init_ctl", {sram_cen, sram_gwen, |sram_wen, |sram_d, arb_ready, a_gnt, b_gnt}, 7'b0);
            chk("init_addr", sram_a, k);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ready_after_sweep();
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        chk("ready_after_init", arb_ready, 1);
        chk("ready_no_gnt", {a_gnt, b_gnt}, 2'b00);
        @(posedge clk);
        #1;
    endtask

    function automatic rq_t rnd_rq();
        rq_t r;
        r.req   = 1'b1;
        r.we    = 1'($urandom % 2);
        r.addr  = ($urandom % 8 == 0) ? 11'h7FF : AW'($urandom % 16);
        r.wdata = $urandom;
        r.be    = ($urandom % 8 == 0) ? 4'h0 : 4'($urandom);
        return r;
    endfunction

    function automatic rq_t mk(input logic req, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [3:0] be);
        rq_t r;
        r.req = req; r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
        return r;
    endfunction

    initial begin
        rq_t  ra, rb, idle;
        logic ga, gb;
        idle = mk(1'b0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0; a_be = '0; b_be = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sram_arr[i] = INIT_EN ? (32'hA5A50000 | i) : 32'h0;
            ref_mem[i]  = '0;
        end
        sram_q = '0;

        @(negedge clk);
        chk("rst_gnt", {a_gnt, b_gnt}, 2'b00);
        chk("rst_rvld", {a_rvld, b_rvld}, 2'b00);
        chk("rst_rdata", rdata, 0);
        chk("rst_cen", sram_cen, 1);
        chk("rst_ready", arb_ready, !INIT_EN);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        if (INIT_EN) begin
            init_sweep(1000);
            rst = 1'b1;
            #1;
            chk("midinit_rst_cen", sram_cen, 1);
            @(posedge clk);
            #1;
            rst = 1'b0;
            init_sweep(2048);
            ready_after_sweep();
        end

        // First RUN cycle: read of address 0 is granted immediately
        step(mk(1'b1, 1'b0, 11'h000, '0, '0), idle, ga, gb);
        chk("first_read_gnt", last_a_gnt, 1);

        step(mk(1'b1, 1'b1, 11'h010, 32'hDEADBEEF, 4'b0101), idle, ga, gb);
        step(mk(1'b1, 1'b0, 11'h010, '0, '0), idle, ga, gb);
        chk("be_merge_rvld", a_rvld, 1);
        chk("be_merge_rdata", rdata, 32'h00AD00EF);
        step(idle, idle, ga, gb);

        // Both requesters continuously busy: grants must alternate starting with A
        ra = mk(1'b1, 1'b1, 11'h020, 32'h11110000, 4'hF);
        rb = mk(1'b1, 1'b1, 11'h030, 32'h22220000, 4'hF);
        for (int i = 0; i < 6; i++) begin
            step(ra, rb, ga, gb);
            chk("rr_alternate_a", last_a_gnt, (i % 2 == 0));
            chk("rr_alternate_b", last_b_gnt, (i % 2 == 1));
            if (ga) begin ra.addr = ra.addr + 1; ra.wdata = ra.wdata + 1; end
            if (gb) begin rb.addr = rb.addr + 1; rb.wdata = rb.wdata + 1; end
        end

        step(idle, mk(1'b1, 1'b0, 11'h7FF, '0, '0), ga, gb);
        chk("b_top_gnt", last_b_gnt, 1);
        chk("b_top_rvld", {a_rvld, b_rvld}, 2'b01);
        step(idle, idle, ga, gb);

        ra = idle; rb = idle;
        for (int i = 0; i < 400; i++) begin
            if (!ra.req && $urandom % 3 != 0) ra = rnd_rq();
            else if (ra.req && $urandom % 10 == 0) ra.req = 1'b0;
            if (!rb.req && $urandom % 3 != 0) rb = rnd_rq();
            else if (rb.req && $urandom % 10 == 0) rb.req = 1'b0;
            step(ra, rb, ga, gb);
            if (ga) ra.req = 1'b0;
            if (gb) rb.req = 1'b0;
        end
        step(idle, idle, ga, gb);
        step(idle, idle, ga, gb);

        // Reset lands while a read is in flight: its rvld must never appear
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'h000; b_req = 1'b0;
        @(negedge clk);
        chk("inflight_gnt", a_gnt, 1);
        #2;
        rst = 1'b1;
        sb_q.delete();
        ptr_m = 0;
        @(posedge clk);
        #1;
        chk("inflight_rvld_dropped", {a_rvld, b_rvld}, 2'b00);
        chk("inflight_rdata", rdata, 0);
        a_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (INIT_EN) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            init_sweep(2048);
            ready_after_sweep();
        end

        ra = idle; rb = idle;
        for (int i = 0; i < 60; i++) begin
            if (!ra.req && $urandom % 2 != 0) ra = rnd_rq();
            if (!rb.req && $urandom % 2 != 0) rb = rnd_rq();
            step(ra, rb, ga, gb);
            if (ga) ra.req = 1'b0;
            if (gb) rb.req = 1'b0;
        end
        step(idle, idle, ga, gb);
        step(idle, idle, ga, gb);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ct_spsram_2048x32_arb.md
CT_SPSRAM_2048X32_ARB -- requirements
Module: ct_spsram_2048x32_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning the SRAM word-address width (2048 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the SRAM data width; byte-enable width is DATA_WIDTH/8.
REQ-003 SHALL have port forever_cpuclk, input, 1, the single clock for all state.
REQ-004 SHALL have port cpurst, input, 1, the asynchronous active-high reset.
REQ-005 SHALL have ports a_req, b_req, input, 1 each, requester A and requester B access request.
REQ-006 SHALL have ports a_we, b_we, input, 1 each, 1 = write, 0 = read.
REQ-007 SHALL have ports a_addr, b_addr, input, ADDR_WIDTH each, word address.
REQ-008 SHALL have ports a_wdata, b_wdata, input, DATA_WIDTH each, write data.
REQ-009 SHALL have ports a_be, b_be, input, 4 each, active-high byte enables.
REQ-010 SHALL have ports a_gnt, b_gnt, output, 1 each, request accepted this cycle.
REQ-011 SHALL have ports a_rvld, b_rvld, output, 1 each, read data valid for that requester.
REQ-012 SHALL have port rdata, output, DATA_WIDTH, read data shared by both requesters, qualified by a_rvld or b_rvld.
REQ-013 SHALL have port arb_ready, output, 1, initialisation complete and arbiter accepting requests.
REQ-014 SHALL have ports sram_cen (1), sram_gwen (1), sram_wen (DATA_WIDTH) and sram_a (ADDR_WIDTH), outputs, active-low SRAM controls and address.
REQ-015 SHALL have port sram_d, output, DATA_WIDTH, and port sram_q, input, DATA_WIDTH, SRAM write data and read data.

Function
REQ-016 SHALL implement FSM states INIT, RUN; reset enters INIT when CT_SPSRAM_ARB_INIT_EN is defined, otherwise RUN.
REQ-017 INIT SHALL write zero to addresses 0..2047 in order, one per cycle: sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=counter.
REQ-018 After the write to address 2047 the FSM SHALL enter RUN on the next edge; INIT SHALL last exactly 2048 cycles; the counter SHALL not wrap.
REQ-019 arb_ready SHALL be 1 only in RUN; a_gnt and b_gnt SHALL be 0 in INIT regardless of requests.
REQ-020 In RUN, grants SHALL be combinational in the request cycle, with at most one grant per cycle.
REQ-021 With a single requester active, that requester SHALL be granted.
REQ-022 With both active, the requester named by a 1-bit round-robin pointer SHALL be granted; the pointer SHALL move to the other requester after every contended grant and hold otherwise; pointer reset value SHALL be A.
REQ-023 A granted access SHALL drive sram_cen=0, sram_a=addr, sram_gwen=~we, sram_d=wdata, and sram_wen byte i bits = ~be[i] for writes (all ones for reads).
REQ-024 With no grant, sram_cen SHALL be 1, sram_gwen 1 and sram_wen all ones.
REQ-025 A granted read SHALL assert that requester's rvld exactly one cycle later, with rdata=sram_q; back-to-back reads SHALL give back-to-back rvld.
REQ-026 A write with be=0 SHALL be granted and SHALL modify no bits.
REQ-027 Requesters SHALL hold req and payload until granted; a dropped request SHALL simply not be granted.

Reset
REQ-028 On cpurst: a_gnt=b_gnt=0, a_rvld=b_rvld=0, rdata=0, pointer=A, INIT counter=0, sram_cen=1; arb_ready=0 if CT_SPSRAM_ARB_INIT_EN is defined, else 1.
REQ-029 Reset asserted mid-INIT SHALL restart the sweep from address 0; reset with a read in flight SHALL discard the pending rvld.

Configuration
REQ-030 Macro CT_SPSRAM_ARB_INIT_EN defined SHALL include the INIT state and counter; undefined SHALL omit them, with arb_ready tied to 1 and RUN active from reset release.

Verification
REQ-031 INIT_EN defined, release reset -> 2048 zero writes to addresses 0..2047, arb_ready rises on cycle 2048, no grants before then.
REQ-032 A writes 0xDEADBEEF to 0x10 with be=4'b0101, then reads 0x10 -> a_rvld one cycle after grant, rdata=0x00AD00EF.
REQ-033 A and B both request continuously for 6 cycles -> grants alternate A,B,A,B,A,B.
REQ-034 B reads 0x7FF while A is idle -> b_gnt same cycle, b_rvld next cycle, a_rvld stays 0.
REQ-035 Assert reset at INIT counter 1000 -> sweep restarts at address 0 and arb_ready rises 2048 cycles after release.
REQ-036 INIT_EN undefined -> arb_ready=1 in the first cycle after reset, and an A read of 0x0 is granted immediately.
